// File: rtl/uart_pkg.sv
// Shared UART constants (baud end values at 50 MHz) and FSM state encoding for the TX and RX paths.
// No logic; baud end value = (f_clk / baud) - 1.
package uart_pkg;

  localparam int unsigned BAUD_END_115200 = 433;
  localparam int unsigned BAUD_END_9600   = 5207;
  localparam int unsigned BAUD_END_SIM    = 28;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter 0..BAUD_END while enabled, o_bit_end combinational on the last count.
// Clears to 0 when disabled and wraps to 0 on every bit end; no backpressure.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_END = BAUD_END_115200
) (
  input  logic sclk,
  input  logic s_rst_n,
  input  logic i_en,
  output logic o_bit_end
);

  localparam int unsigned W = $clog2(BAUD_END + 1);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last    = (r_cnt == W'(BAUD_END));
  assign o_bit_end = i_en & w_last;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter (8E1/8E2 with UART_TX_PARITY_EN) with a one-entry holding register.
// Line goes low 2 cycles after accept; tx_ready = holding register empty, frames chain with no idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_END  = BAUD_END_115200,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       rs232_tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_e r_state, w_state_nxt;
  logic [7:0]  r_hold, r_shift, w_shift_nxt;
  logic [2:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic        r_hold_full, r_tx, r_done;
  logic        w_bit_end, w_accept, w_load, w_done, w_tx_nxt;
`ifdef UART_TX_PARITY_EN
  logic        r_par;
`endif

  assign w_accept = tx_valid & ~r_hold_full;
  assign tx_ready = ~r_hold_full;
  assign rs232_tx = r_tx;
  assign tx_busy  = (r_state != ST_IDLE);
  assign tx_done  = r_done;

  uart_baud_cnt #(.BAUD_END(BAUD_END)) u_baud (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .i_en      (r_state != ST_IDLE),
    .o_bit_end (w_bit_end)
  );

  // Accept and load never coincide on a full register, so the hold flag has one writer per cycle.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold <= tx_data;
      end
      r_hold_full <= w_accept | (r_hold_full & ~w_load);
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_par <= 1'b0;
    end else if (w_load) begin
      r_par <= even_parity(r_hold);
    end
  end
`endif

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_tx      <= w_tx_nxt;
      r_done    <= w_done;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_load        = 1'b0;
    w_done        = 1'b0;
    w_tx_nxt      = 1'b1;

    unique case (r_state)
      ST_IDLE: begin
        if (r_hold_full) begin
          w_load      = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt   = ST_DATA;
          w_bit_cnt_nxt = '0;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) begin
            w_bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
            w_state_nxt   = ST_PARITY;
`else
            w_state_nxt   = ST_STOP;
`endif
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_bit_end) begin
          if (r_bit_cnt == LAST_STOP) begin
            w_done        = 1'b1;
            w_bit_cnt_nxt = '0;
            if (r_hold_full) begin
              w_load      = 1'b1;
              w_state_nxt = ST_START;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_load) begin
      w_shift_nxt = r_hold;
    end

    // The line is registered from the next state so it switches on the same edge as the FSM.
    unique case (w_state_nxt)
      ST_START: w_tx_nxt = 1'b0;
      ST_DATA:  w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_tx_nxt = r_par;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomised and directed bench for uart_tx: a mid-bit sampling receiver model recovers each frame.
// Runs with or without UART_TX_PARITY_EN.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int BE = BAUD_END_SIM;
  localparam int BP = BE + 1;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       sclk    = 1'b0;
  logic       s_rst_n = 1'b0;
  logic [7:0] d1 = '0, d2 = '0;
  logic       v1 = 1'b0, v2 = 1'b0;
  logic       rdy1, tx1, busy1, done1;
  logic       rdy2, tx2, busy2, done2;
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  uart_tx #(.BAUD_END(BE), .STOP_BITS(1)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .tx_data(d1), .tx_valid(v1),
    .tx_ready(rdy1), .rs232_tx(tx1), .tx_busy(busy1), .tx_done(done1)
  );

  uart_tx #(.BAUD_END(BE), .STOP_BITS(2)) dut2 (
    .sclk(sclk), .s_rst_n(s_rst_n), .tx_data(d2), .tx_valid(v2),
    .tx_ready(rdy2), .rs232_tx(tx2), .tx_busy(busy2), .tx_done(done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic line_of(input int sel);
    return (sel != 0) ? tx2 : tx1;
  endfunction
  function automatic logic done_of(input int sel);
    return (sel != 0) ? done2 : done1;
  endfunction
  function automatic logic rdy_of(input int sel);
    return (sel != 0) ? rdy2 : rdy1;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel != 0) ? busy2 : busy1;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_byte(input int sel, input logic [7:0] b, input bit keep, output int acc);
    int n;
    n = 0;
    if (sel != 0) begin v2 = 1'b1; d2 = b; end
    else begin v1 = 1'b1; d1 = b; end
    while (!rdy_of(sel) && n < 3000) begin
      @(negedge sclk);
      n++;
    end
    if (n >= 3000) check("accept_timeout", 0, 1);
    acc = cyc;
    @(negedge sclk);
    if (!keep) begin
      if (sel != 0) v2 = 1'b0;
      else v1 = 1'b0;
    end
  endtask

  // Receiver model: find the start bit, sample each bit at its middle, check framing and tx_done timing.
  task automatic expect_frame(input int sel, input int nstop, output logic [7:0] got, output int st);
    int   frame;
    int   n;
    int   bad;
    int   early;
    logic s;
    frame = (9 + P + nstop) * BP;
    n     = 0;
    bad   = 0;
    early = 0;
    got   = '0;
    st    = cyc;
    while (line_of(sel) !== 1'b0 && n < 3000) begin
      @(negedge sclk);
      n++;
    end
    if (n >= 3000) begin
      check("start_timeout", 0, 1);
      return;
    end
    st = cyc;
    for (int off = 0; off < frame; off++) begin
      if (off % BP == BP / 2) begin
        int k;
        k = off / BP;
        s = line_of(sel);
        if (k == 0) begin
          if (s !== 1'b0) bad++;
        end else if (k <= 8) begin
          got[k-1] = s;
        end else if (P == 1 && k == 9) begin
          if (s !== ^got) bad++;
        end else begin
          if (s !== 1'b1) bad++;
        end
      end
      if (off > 0 && done_of(sel) !== 1'b0) early++;
      if (off == BP * 5) check("busy_mid_frame", busy_of(sel), 1);
      @(negedge sclk);
    end
    check("framing_bits", bad, 0);
    check("done_not_early", early, 0);
    check("done_at_frame_end", done_of(sel), 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b, b2;
    logic [7:0] q[$];
    logic [7:0] dir[2];
    int s1, s2, acc, bad;

    repeat (3) @(negedge sclk);
    check("rst_line", tx1, 1);
    check("rst_ready", rdy1, 1);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    s_rst_n = 1'b1;

    bad = 0;
    repeat (100) begin
      @(negedge sclk);
      if (tx1 !== 1'b1 || done1 !== 1'b0 || rdy1 !== 1'b1 || busy1 !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);

    fork
      send_byte(0, 8'h55, 1'b0, acc);
      expect_frame(0, 1, b, s1);
    join
    check("byte_55", b, 8'h55);
    check("accept_to_start", s1 - acc, 2);

    fork
      begin
        send_byte(0, 8'hA3, 1'b1, acc);
        d1 = 8'h0F;
        check("ready_low_between", rdy1, 0);
        send_byte(0, 8'h0F, 1'b0, acc);
      end
      begin
        expect_frame(0, 1, b, s1);
        expect_frame(0, 1, b2, s2);
      end
    join
    check("byte_A3", b, 8'hA3);
    check("byte_0F", b2, 8'h0F);
    check("b2b_spacing", s2 - s1, (10 + P) * BP);

    dir[0] = 8'h07;
    dir[1] = 8'h03;
    for (int i = 0; i < 2; i++) begin
      fork
        send_byte(0, dir[i], 1'b0, acc);
        expect_frame(0, 1, b, s1);
      join
      check("parity_vec_byte", b, dir[i]);
    end

    fork
      send_byte(1, 8'h00, 1'b0, acc);
      expect_frame(1, 2, b, s1);
    join
    check("two_stop_byte", b, 8'h00);

    fork
      for (int i = 0; i < 8; i++) begin
        int gap;
        b = 8'($urandom);
        gap = (($urandom & 1) != 0) ? 0 : int'($urandom_range(1, 40));
        q.push_back(b);
        send_byte(0, b, (gap == 0 && i != 7), acc);
        repeat (gap) @(negedge sclk);
      end
      for (int i = 0; i < 8; i++) begin
        expect_frame(0, 1, b2, s2);
        if (q.size() == 0) check("queue_underflow", 0, 1);
        else check("random_byte", b2, q.pop_front());
      end
    join

    send_byte(0, 8'hFF, 1'b1, acc);
    send_byte(0, 8'h00, 1'b0, acc);
    repeat (BP * 5 + 5) @(negedge sclk);
    #2 s_rst_n = 1'b0;
    #1;
    check("rst_mid_line", tx1, 1);
    check("rst_mid_busy", busy1, 0);
    check("rst_mid_ready", rdy1, 1);
    @(negedge sclk);
    s_rst_n = 1'b1;
    bad = 0;
    repeat (400) begin
      @(negedge sclk);
      if (done1 !== 1'b0 || tx1 !== 1'b1 || busy1 !== 1'b0) bad++;
    end
    check("post_reset_quiet", bad, 0);
    check("post_reset_ready", rdy1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
